// File: rtl/mfe_rd_arbiter.sv
// -----------------------------------------------------------------------------
// mfe_rd_arbiter
// Round-robin, burst-granular arbiter that shares the single image-memory read
// port between N_REQ window fetchers. A requester owns the port for a whole
// burst (up to MAX_BURST beats), and the read data is routed back to the
// requester that issued each beat after a fixed two-cycle latency.
//
// Ports
//   clk       : clock, all logic on rising edge
//   reset     : synchronous, active-high
//   req       : per-requester read request (level)
//   req_addr  : flattened addresses, requester i at [i*AW +: AW]
//   req_last  : final beat of the requester's burst
//   gnt       : one-hot beat accept (combinational)
//   rvalid    : one-hot read-data valid (registered)
//   rdata     : returned pixel (registered)
//   iaddr     : image memory address (registered)
//   idata     : image memory data, valid the cycle after iaddr changes
//   busy      : high while a burst is owned
//   owner     : index of the current or last owner
// -----------------------------------------------------------------------------
module mfe_rd_arbiter #(
    parameter int N_REQ     = 2,
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int MAX_BURST = 9,
    localparam int OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rvalid,
    output logic [DW-1:0]         rdata,
    output logic [AW-1:0]         iaddr,
    input  logic [DW-1:0]         idata,
    output logic                  busy,
    output logic [OW-1:0]         owner
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [OW-1:0]      rr_ptr_r;
    logic [OW-1:0]      owner_r;
    logic [CW-1:0]      beat_cnt_r;
    logic [AW-1:0]      iaddr_r;
    logic [DW-1:0]      rdata_r;
    logic [N_REQ-1:0]   rvalid_r;
    logic               slot_v_r;
    logic [OW-1:0]      slot_id_r;

    logic               pick_found_s;
    logic [OW-1:0]      pick_idx_s;
    int                 cand_s;
    logic [N_REQ-1:0]   gnt_s;
    logic               accept_s;
    logic               owner_req_s;
    logic               owner_last_s;
    logic [AW-1:0]      owner_addr_s;
    logic [CW-1:0]      cnt_next_s;
    logic               release_s;
    logic [OW-1:0]      rr_next_s;

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = int'(rr_ptr_r) + i;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (!pick_found_s && req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = OW'(cand_s);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Owner view of the request bus and the beat grant; no grant during reset.
    always_comb begin
        owner_req_s  = req[owner_r];
        owner_last_s = req_last[owner_r];
        owner_addr_s = req_addr[int'(owner_r)*AW +: AW];
        gnt_s        = '0;
        if (!reset && (state_r == ST_BURST)) begin
            gnt_s[owner_r] = owner_req_s;
        end else begin
            gnt_s = '0;
        end
        accept_s   = |gnt_s;
        cnt_next_s = beat_cnt_r + CW'(1);
    end

    // Burst release: last beat flagged, beat limit reached, or owner dropped req.
    always_comb begin
        release_s = 1'b0;
        if (state_r == ST_BURST) begin
            release_s = !owner_req_s ||
                        (accept_s && (owner_last_s || (cnt_next_s == CW'(MAX_BURST))));
        end else begin
            release_s = 1'b0;
        end
        if (owner_r == OW'(N_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = owner_r + OW'(1);
        end
    end

    // Next-state logic; the arbitration cycle in IDLE never carries a beat.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_s = ST_BURST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (release_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Control registers: state, round-robin pointer, owner and beat count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && pick_found_s) begin
                owner_r    <= pick_idx_s;
                beat_cnt_r <= '0;
            end else if (accept_s) begin
                beat_cnt_r <= cnt_next_s;
            end
            if (release_s) begin
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    // Datapath: address issue, one-slot return pipe tagged with the owner id,
    // then data capture. In-flight slots complete even after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            iaddr_r   <= '0;
            slot_v_r  <= 1'b0;
            slot_id_r <= '0;
            rdata_r   <= '0;
            rvalid_r  <= '0;
        end else begin
            if (accept_s) begin
                iaddr_r <= owner_addr_s;
            end
            slot_v_r  <= accept_s;
            slot_id_r <= owner_r;
            rvalid_r  <= '0;
            if (slot_v_r) begin
                rvalid_r[slot_id_r] <= 1'b1;
                rdata_r             <= idata;
            end
        end
    end

    assign gnt    = gnt_s;
    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign iaddr  = iaddr_r;
    assign busy   = (state_r == ST_BURST);
    assign owner  = owner_r;

endmodule

// File: tb/tb_mfe_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mfe_rd_arbiter
// Directed bench for mfe_rd_arbiter (N_REQ=2, AW=14, DW=8, MAX_BURST=9).
// Each step states the expected grant and busy; a one-slot return model built
// from those expected grants predicts rvalid, rdata and iaddr.
// -----------------------------------------------------------------------------
module tb_mfe_rd_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [27:0] req_addr;
    logic [1:0]  req_last;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic [13:0] iaddr;
    logic [7:0]  idata;
    logic        busy;
    logic [0:0]  owner;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected-return model state.
    logic        pend_v;
    logic        pend_id;
    logic [13:0] pend_a;
    logic [1:0]  exp_rv;
    logic [7:0]  exp_rd;
    logic [13:0] exp_ia;

    mfe_rd_arbiter #(
        .N_REQ(2), .AW(14), .DW(8), .MAX_BURST(9)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_last(req_last), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .iaddr(iaddr), .idata(idata), .busy(busy), .owner(owner)
    );

    // Image memory contents as a function of address.
    function automatic logic [7:0] pix(input logic [13:0] a);
        return (a[7:0] * 8'd3) + {2'b00, a[13:8]} + 8'd17;
    endfunction

    // Memory model: data follows the registered address.
    always_comb idata = pix(iaddr);

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [13:0] a0,
                         input logic [13:0] a1, input logic [1:0] l);
        req      = r;
        req_addr = {a1, a0};
        req_last = l;
    endtask

    // One clock step: check grant/busy, clock, update model, check returns.
    task automatic tick(input logic [1:0] eg, input logic eb);
        logic        acc;
        logic        id;
        logic [13:0] a;
        #1;
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        chk("busy", {31'd0, busy}, {31'd0, eb});
        acc = |eg;
        id  = eg[1];
        a   = id ? req_addr[27:14] : req_addr[13:0];
        @(posedge clk);
        if (reset) begin
            pend_v = 1'b0;
            exp_rv = 2'b00;
            exp_rd = 8'd0;
            exp_ia = 14'd0;
        end else begin
            exp_rv = pend_v ? (pend_id ? 2'b10 : 2'b01) : 2'b00;
            if (pend_v) exp_rd = pix(pend_a);
            pend_v  = acc;
            pend_id = id;
            pend_a  = a;
            if (acc) exp_ia = a;
        end
        #1;
        chk("rvalid", {30'd0, rvalid}, {30'd0, exp_rv});
        chk("rdata", {24'd0, rdata}, {24'd0, exp_rd});
        chk("iaddr", {18'd0, iaddr}, {18'd0, exp_ia});
    endtask

    task automatic chk_owner(input logic eo);
        chk("owner", {31'd0, owner}, {31'd0, eo});
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 14'd0, 14'd0, 2'b00);
        pend_v = 1'b0; pend_id = 1'b0; pend_a = 14'd0;
        exp_rv = 2'b00; exp_rd = 8'd0; exp_ia = 14'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
        chk("rst_iaddr", {18'd0, iaddr}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk_owner(1'b0);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        reset = 1'b0;

        // Single requester: one dead cycle, then 9 beats at addr 0..8.
        drive(2'b01, 14'd0, 14'd0, 2'b00);
        tick(2'b00, 1'b0);
        chk_owner(1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(2'b01, 14'(i), 14'd0, (i == 8) ? 2'b01 : 2'b00);
            tick(2'b01, 1'b1);
        end
        drive(2'b00, 14'd0, 14'd0, 2'b00);
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b0);

        // rr_ptr is now 1: both requesting picks requester 1.
        drive(2'b11, 14'd50, 14'd200, 2'b11);
        tick(2'b00, 1'b0);
        chk_owner(1'b1);
        tick(2'b10, 1'b1);
        drive(2'b00, 14'd0, 14'd0, 2'b00);
        tick(2'b00, 1'b0);

        // Beat-limit cut: requester 1 wants 12 beats, no req_last.
        drive(2'b10, 14'd0, 14'd300, 2'b00);
        tick(2'b00, 1'b0);
        chk_owner(1'b1);
        for (int i = 0; i < 9; i++) begin
            drive(2'b10, 14'd0, 14'(300 + i), 2'b00);
            tick(2'b10, 1'b1);
        end
        drive(2'b10, 14'd0, 14'd309, 2'b00);
        tick(2'b00, 1'b0);
        chk_owner(1'b1);
        for (int i = 9; i < 12; i++) begin
            drive(2'b10, 14'd0, 14'(300 + i), 2'b00);
            tick(2'b10, 1'b1);
        end
        drive(2'b00, 14'd0, 14'd0, 2'b00);
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b0);

        // Fairness: both requesting, 3-beat bursts, owners 0,1,0,1.
        for (int b = 0; b < 4; b++) begin
            drive(2'b11, 14'(400 + b * 3), 14'(500 + b * 3), 2'b00);
            tick(2'b00, 1'b0);
            chk_owner(1'(b % 2));
            for (int j = 0; j < 3; j++) begin
                drive(2'b11, 14'(400 + b * 3 + j), 14'(500 + b * 3 + j),
                      (j == 2) ? 2'b11 : 2'b00);
                tick(((b % 2) == 1) ? 2'b10 : 2'b01, 1'b1);
            end
        end

        // Early drop: owner 0 stops after 4 beats, requester 1 waiting.
        drive(2'b11, 14'd600, 14'd700, 2'b00);
        tick(2'b00, 1'b0);
        chk_owner(1'b0);
        for (int j = 0; j < 4; j++) begin
            drive(2'b11, 14'(600 + j), 14'd700, 2'b00);
            tick(2'b01, 1'b1);
        end
        drive(2'b10, 14'd600, 14'd700, 2'b00);
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b0);
        chk_owner(1'b1);
        for (int j = 0; j < 2; j++) begin
            drive(2'b10, 14'd0, 14'(700 + j), (j == 1) ? 2'b10 : 2'b00);
            tick(2'b10, 1'b1);
        end

        // Overlap: requester 0 releases with beats in flight while 1 arbitrates.
        drive(2'b11, 14'd800, 14'd900, 2'b00);
        tick(2'b00, 1'b0);
        chk_owner(1'b0);
        for (int j = 0; j < 2; j++) begin
            drive(2'b11, 14'(800 + j), 14'd900, (j == 1) ? 2'b01 : 2'b00);
            tick(2'b01, 1'b1);
        end
        drive(2'b10, 14'd0, 14'd900, 2'b00);
        tick(2'b00, 1'b0);
        chk_owner(1'b1);

        // Reset after beat 5 of requester 1's burst (rr_ptr is 1 here).
        for (int j = 0; j < 5; j++) begin
            drive(2'b11, 14'd1000, 14'(900 + j), 2'b00);
            tick(2'b10, 1'b1);
        end
        reset = 1'b1;
        drive(2'b11, 14'd1000, 14'd905, 2'b00);
        tick(2'b00, 1'b1);
        reset = 1'b0;
        drive(2'b11, 14'd1000, 14'd905, 2'b00);
        tick(2'b00, 1'b0);
        chk_owner(1'b0);
        drive(2'b11, 14'd1000, 14'd905, 2'b01);
        tick(2'b01, 1'b1);
        drive(2'b00, 14'd0, 14'd0, 2'b00);
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
